md_sequencer: RTL
=================

# md_sequencer

Multi-cycle sequencing control for the M-extension in the RV32ICMFA pipeline. Decodes MUL/DIV/REM in the decode stage and latches the operand-signedness and high-part selection. Holds the pipeline stalled for a per-class, parameterised latency and signals result-ready to writeback. Extends the combinational mul/div decode with latency counting, flush handling and a divide-by-zero fast path.

## Interface
Parameters:
- MUL_LAT, 2, cycles from accept to `md_done` for funct3[2]=0 (MUL*); must be ≥2
- DIV_LAT, 32, cycles from accept to `md_done` for funct3[2]=1 (DIV/REM); must be ≥2
- DIV_ZERO_FAST, 1, when 1 a divide with `rs2_zero`=1 completes in 1 cycle

Ports:
- clk  in  1  single clock; everything samples on the rising edge
- rst  in  1  reset, synchronous and active-high
- valid_i  in  1  decode-stage instruction valid
- op  in  7  opcode
- funct3  in  3  funct3
- funct7  in  7  funct7
- rs2_zero  in  1  divisor operand equals 0 (forwarded value)
- flush  in  1  kill the in-flight or presented instruction
- stall  out  1  hold the fetch/decode registers
- md_start  out  1  one-cycle start pulse to the datapath
- md_kill  out  1  one-cycle abort pulse to the datapath
- md_done  out  1  one-cycle result-valid pulse to writeback
- md_funct3  out  3  latched funct3 of the active op
- Mul_Div_unsigned  out  2  latched signedness: [1]=rs1 unsigned, [0]=rs2 unsigned
- is_high  out  1  latched: upper product half (MULH*) or remainder (REM*)

## Operation
- is_md = (op==7'b0110011) && (funct7==7'b0000001).
- Signedness encoding by funct3:
  - 000/001/100/110 → 2'b00
  - 010 → 2'b01
  - 011/101/111 → 2'b11
- is_high = 1 for funct3 ∈ {001,010,011,110,111}; 0 otherwise.
- States: IDLE, BUSY, DONE.
- IDLE:
  - accept = valid_i && is_md && !flush.
  - On accept: pulse `md_start`, latch funct3/signedness/is_high, load cnt = LAT−1 (LAT by funct3[2]).
  - Next state: DONE if DIV_ZERO_FAST && funct3[2] && rs2_zero; otherwise BUSY.
- BUSY:
  - flush → pulse `md_kill`, next IDLE, no `md_done`.
  - Else if cnt==1 → DONE; else cnt−1.
- DONE: `md_done`=1 for exactly this cycle; next IDLE unconditionally; flush ignored.
- cnt width = $clog2(DIV_LAT+1); never decremented below 1.
- Non-M instructions and `valid_i`=0 leave the block in IDLE with all pulses low.
- Latched outputs hold their value from the accept edge until the next accept; they do not return to 0 in IDLE.

## Timing
- Reset: state IDLE, cnt=0. `stall`, `md_start`, `md_kill`, `md_done`, `md_funct3`, `Mul_Div_unsigned`, `is_high` all 0.
- stall = (IDLE && accept) || BUSY. Combinational, so it is high in the accept cycle itself. Low in DONE.
- `md_start`, `md_kill`, `md_done` are combinational from state/inputs:
  - md_start = IDLE && accept
  - md_kill = BUSY && flush
  - md_done = DONE
- Latency: accept in cycle 0 → `md_done` in cycle LAT. `stall` is high for cycles 0..LAT−1 (LAT cycles).
- Fast divide-by-zero: `md_done` in cycle 1; `stall` high in cycle 0 only.
- Back-to-back: an M op presented in the cycle after DONE is accepted (the block is in IDLE). Minimum issue interval is LAT+1 cycles.
- flush with valid M op in IDLE: no accept, `stall`=0, `md_start`=0.
- rst asserted in any state, including mid-BUSY: next cycle IDLE, no `md_done` or `md_kill`, outputs at reset values.

## Test plan
- Reset then MUL (funct3=000, funct7=0000001, op=0110011) with MUL_LAT=2 → `md_start` cycle 0, `stall` cycles 0–1, `md_done` cycle 2, Mul_Div_unsigned=00, is_high=0.
- DIVU, DIV_LAT=32, rs2_zero=0 → `md_done` exactly cycle 32, `stall` 32 cycles, Mul_Div_unsigned=11, is_high=0. Then REM presented on cycle 33 → accepted, is_high=1.
- DIV with rs2_zero=1, DIV_ZERO_FAST=1 → `md_done` cycle 1, `stall` only cycle 0. Same with DIV_ZERO_FAST=0 → `md_done` cycle 32.
- MULHSU accepted, `flush` at cycle 1 → `md_kill`=1 cycle 1, no `md_done`, IDLE at cycle 2, `stall`=0 cycle 2.
- ADD (funct7=0000000) and valid M op with `flush`=1 in IDLE → no `stall`, no pulses. `rst` at cycle 10 of a DIV → no `md_done`, all outputs 0 next cycle.

Source files
------------

// File: rtl/md_sequencer.sv
// Multi-cycle sequencing for RV32 M-extension ops: decodes MUL/DIV/REM, latches
// operand signedness and high-part select, and stalls decode for the op's latency.
module md_sequencer #(
    parameter int MUL_LAT       = 2,
    parameter int DIV_LAT       = 32,
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       rs2_zero,
    input  logic       flush,
    output logic       stall,
    output logic       md_start,
    output logic       md_kill,
    output logic       md_done,
    output logic [2:0] md_funct3,
    output logic [1:0] Mul_Div_unsigned,
    output logic       is_high
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_md;
    logic             accept;
    logic             fast_zero;
    logic [CNT_W-1:0] lat_load;

    // [1] = rs1 unsigned, [0] = rs2 unsigned
    function automatic logic [1:0] signedness(input logic [2:0] f3);
        case (f3)
            3'b010:                 return 2'b01;
            3'b011, 3'b101, 3'b111: return 2'b11;
            default:                return 2'b00;
        endcase
    endfunction

    // Upper product half for MULH*, remainder for REM*
    function automatic logic high_sel(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b010, 3'b011, 3'b110, 3'b111: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    assign is_md     = (op == 7'b0110011) && (funct7 == 7'b0000001);
    assign accept    = valid_i && is_md && !flush;
    assign fast_zero = DIV_ZERO_FAST && funct3[2] && rs2_zero;
    assign lat_load  = funct3[2] ? DIV_LOAD : MUL_LOAD;

    assign stall    = ((state == IDLE) && accept) || (state == BUSY);
    assign md_start = (state == IDLE) && accept;
    assign md_kill  = (state == BUSY) && flush;
    assign md_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            md_funct3        <= '0;
            Mul_Div_unsigned <= '0;
            is_high          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        md_funct3        <= funct3;
                        Mul_Div_unsigned <= signedness(funct3);
                        is_high          <= high_sel(funct3);
                        cnt              <= lat_load;
                        state            <= fast_zero ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    // cnt holds LAT-k in busy cycle k, so cnt==1 lands DONE on cycle LAT
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == CNT_ONE) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
